dmem_mmio_resp: RTL and testbench
=================================

Name: dmem_mmio_resp

Overview:
- Responder for the CPU data-memory port: accepts daddr/dwdata/we from the core and returns drdata.
- Word-addressed RAM is combined with a small MMIO page: free-running cycle counter, byte console with an 8-deep output FIFO, and a TOHOST result register.
- Replaces the bare data memory in the pipeline testbench and on-board top level, so programs can print and report pass/fail.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words (power of 2).
- FIFO_DEPTH, 8, console FIFO entries (power of 2, at least 2).
- INIT_FILE, "", optional $readmemh image for RAM; empty means no preload.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (rst=0 at a clk edge resets)
- daddr  in  32  byte address from CPU
- dwdata  in  32  store data from CPU
- we  in  4  byte write enables; we[i] writes dwdata[8i+7:8i]; 0000 means read/idle
- drdata  out  32  load data to CPU, combinational from daddr
- con_valid  out  1  console FIFO non-empty
- con_data  out  8  console FIFO head byte
- con_ready  in  1  consumer pops head when con_valid & con_ready
- done  out  1  sticky, set by first TOHOST write
- tohost  out  32  last value written to TOHOST

Behaviour:
- Decode: daddr[31]=0 selects RAM; daddr[31]=1 selects MMIO, with register select daddr[3:2] and daddr[30:4] ignored (page aliases). daddr[1:0] is ignored everywhere; accesses are word-aligned.
- RAM: word index is daddr[log2(RAM_WORDS)+1:2], so higher bits wrap. Reads are combinational, same cycle. Writes are byte-masked at clk edge. Contents are not reset. A read of a word written in the same cycle returns the old value.
- MMIO map (offset from 0x8000_0000):
  - 0x0 CYCLE, read-only. 32-bit counter: 0 on reset, +1 every cycle, wraps 0xFFFF_FFFF->0. Writes are ignored.
  - 0x4 CONSOLE_TX, write-only; reads return 0. A write with we[0]=1 pushes dwdata[7:0]. Writes with we[0]=0 are ignored.
  - 0x8 CONSOLE_STAT, read-only.
    - bit0 full.
    - bit1 empty.
    - bit2 overflow: sticky, cleared only by reset.
    - bits[7:4] occupancy count.
    - Other bits 0.
  - 0xC TOHOST, read/write. Read returns tohost. A write with any we bit set updates only the enabled bytes and sets done=1.
- Console FIFO:
  - Circular buffer with rd/wr pointers and a count.
  - Pop when con_valid & con_ready.
  - Push accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle. In that case count is unchanged and ordering is preserved.
  - Push to a full FIFO without a pop is dropped and sets overflow.
  - Push to an empty FIFO: con_valid rises on the next cycle, and con_data then equals the pushed byte.
  - con_data holds the head byte. It is don't-care while con_valid=0 but drives 0 after reset.
  - con_data and con_valid are registered-state outputs with no combinational path from con_ready.
- Reset (rst=0): CYCLE=0, FIFO count=0, both pointers=0, overflow=0, con_valid=0, con_data=0, done=0, tohost=0. RAM is untouched.
  - drdata is still driven combinationally during reset; MMIO reads reflect the reset values.
  - Reset in mid-operation discards FIFO contents. A write presented in the reset cycle is ignored for MMIO; RAM still writes.
- Latency: loads 0 cycles (combinational); stores and pushes visible on the cycle after the edge.

Test Plan:
- Reset then write 0xDEADBEEF to 0x0000_0010 with we=1111, then we=0010 with dwdata=0x0000_5500. Read 0x10 -> 0xDEAD55EF. Read 0x0000_0010+4*RAM_WORDS -> same value (wrap).
- Release reset, wait 10 cycles, read 0x8000_0000 -> 10 (±0 by exact edge count). Write 0x1234 to it -> next read continues counting and is not 0x1234.
- con_ready=0; write bytes 'H','i' to 0x8000_0004 -> STAT reads count=2, empty=0. Raise con_ready -> con_data 0x48 then 0x69 on consecutive cycles, then con_valid=0, STAT empty=1.
- con_ready=0; push 9 bytes -> STAT full=1, count=8, overflow=1, and the 9th byte is never output. Push with con_ready=1 while full -> byte accepted, count stays 8.
- Write 0x00000001 to 0x8000_000C with we=0001 -> done=1, tohost=1. Assert rst=0 for one cycle -> done=0, tohost=0, con_valid=0, CYCLE=0.
- Write to 0x8000_0014 (alias of 0x4) with we=0001 -> byte pushed. Write to CONSOLE_TX with we=1110 -> no push.

Source files
------------

// File: rtl/dmem_mmio_resp_if.sv
// CPU data-memory bus between the core (master) and the memory/MMIO responder (slave).
// Loads are combinational: drdata follows daddr within the same cycle.
interface dmem_mmio_resp_if;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;

  modport master (output daddr, output dwdata, output we, input drdata);
  modport slave  (input daddr, input dwdata, input we, output drdata);
endinterface

// File: rtl/dmem_mmio_resp.sv
// Data-memory responder: word RAM below 0x8000_0000, and above it an MMIO page
// holding a cycle counter, a byte console FIFO and a TOHOST result register.
module dmem_mmio_resp #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter     INIT_FILE  = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_mmio_resp_if.slave      bus,
  output logic                 con_valid,
  output logic [7:0]           con_data,
  input  logic                 con_ready,
  output logic                 done,
  output logic [31:0]          tohost
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (CW < 4) ? CW : 4;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];

  logic [31:0]   cycle_q, cycle_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic [31:0]   tohost_q, tohost_d;

  logic          ram_sel;
  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_sel;
  logic          push;
  logic          pop;
  logic          accept;
  logic          fifo_full;
  logic          tohost_wr;
  logic [31:0]   stat;
  logic          unused_addr_bits;

  // Upper RAM-alias bits and the byte offset never influence the access.
  assign unused_addr_bits = ^{bus.daddr[30:AW+2], bus.daddr[1:0]};

  // Address decode and FIFO handshake qualifiers.
  always_comb begin
    ram_sel   = ~bus.daddr[31];
    ram_idx   = bus.daddr[AW+1:2];
    reg_sel   = bus.daddr[3:2];
    fifo_full = (count_q == CW'(FIFO_DEPTH));
    pop       = con_valid & con_ready;
    push      = bus.daddr[31] & (reg_sel == 2'd1) & bus.we[0];
    // A pop in the same cycle frees the head slot, so a full FIFO can still take the byte.
    accept    = push & (~fifo_full | pop);
    tohost_wr = bus.daddr[31] & (reg_sel == 2'd3) & (bus.we != 4'b0000);
  end

  // Next-state for counter, FIFO bookkeeping and TOHOST.
  always_comb begin
    cycle_d    = cycle_q + 32'd1;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & ~accept);
    done_d     = done_q | tohost_wr;
    tohost_d   = tohost_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (accept && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!accept && pop) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    for (int b = 0; b < 4; b++) begin
      if (tohost_wr && bus.we[b]) begin
        tohost_d[8*b +: 8] = bus.dwdata[8*b +: 8];
      end else begin
        tohost_d[8*b +: 8] = tohost_q[8*b +: 8];
      end
    end
  end

  // MMIO state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q    <= 32'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      tohost_q   <= 32'd0;
    end else begin
      cycle_q    <= cycle_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      tohost_q   <= tohost_d;
    end
  end

  // Console storage; pushes presented during reset are discarded.
  always_ff @(posedge clk) begin
    if (rst && accept) begin
      fifo_q[wr_ptr_q] <= bus.dwdata[7:0];
    end
  end

  // Byte-masked RAM writes; RAM keeps its contents and still writes through reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_sel && bus.we[b]) begin
        ram_q[ram_idx][8*b +: 8] <= bus.dwdata[8*b +: 8];
      end
    end
  end

  // Load mux: RAM word or MMIO register, purely combinational from daddr.
  always_comb begin
    stat          = 32'd0;
    stat[0]       = fifo_full;
    stat[1]       = ~con_valid;
    stat[2]       = overflow_q;
    stat[4 +: SW] = count_q[SW-1:0];
    if (ram_sel) begin
      bus.drdata = ram_q[ram_idx];
    end else begin
      case (reg_sel)
        2'd0:    bus.drdata = cycle_q;
        2'd1:    bus.drdata = 32'd0;
        2'd2:    bus.drdata = stat;
        2'd3:    bus.drdata = tohost_q;
        default: bus.drdata = 32'd0;
      endcase
    end
  end

  assign con_valid = (count_q != '0);
  assign con_data  = con_valid ? fifo_q[rd_ptr_q] : 8'd0;
  assign done      = done_q;
  assign tohost    = tohost_q;

endmodule

// File: tb/tb_dmem_mmio_resp.sv
// Self-checking bench for dmem_mmio_resp: directed scenarios plus a randomized
// run, all compared against a queue/array reference model of the memory map.
module tb_dmem_mmio_resp;
  localparam int WORDS = 1024;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        done;
  logic [31:0] tohost;

  dmem_mmio_resp_if bus ();

  dmem_mmio_resp #(.RAM_WORDS(WORDS), .FIFO_DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
    .done(done), .tohost(tohost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model
  logic [31:0] ram_m [WORDS];
  logic [31:0] mcyc;
  logic [7:0]  mq [$];
  logic        movf;
  logic        mdone;
  logic [31:0] mtohost;

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [31:0] s;
    if (a[31] == 1'b0) return ram_m[a[11:2]];
    case (a[3:2])
      2'd0: return mcyc;
      2'd2: begin
        s = 32'd0;
        s[0] = (mq.size() == DEPTH);
        s[1] = (mq.size() == 0);
        s[2] = movf;
        s[7:4] = 4'(mq.size());
        return s;
      end
      2'd3: return mtohost;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.daddr = a;
    bus.dwdata = d;
    bus.we = w;
  endtask

  // One clock edge: the model advances from the inputs currently applied.
  task automatic cyc();
    if (bus.daddr[31] == 1'b0) begin
      for (int b = 0; b < 4; b++)
        if (bus.we[b]) ram_m[bus.daddr[11:2]][8*b +: 8] = bus.dwdata[8*b +: 8];
    end
    if (!rst) begin
      mcyc = 32'd0; mq.delete(); movf = 1'b0; mdone = 1'b0; mtohost = 32'd0;
    end else begin
      mcyc = mcyc + 32'd1;
      if (mq.size() > 0 && con_ready) void'(mq.pop_front());
      if (bus.daddr[31] && bus.daddr[3:2] == 2'd1 && bus.we[0]) begin
        if (mq.size() < DEPTH) mq.push_back(bus.dwdata[7:0]);
        else movf = 1'b1;
      end
      if (bus.daddr[31] && bus.daddr[3:2] == 2'd3 && bus.we != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (bus.we[b]) mtohost[8*b +: 8] = bus.dwdata[8*b +: 8];
        mdone = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; con_ready = 1'b0;
    drive(32'h8000_0000, 32'd0, 4'b0000);
    cyc(); cyc();
    total_cnt++; if (con_valid !== 1'b0) $display("FAIL reset_con_valid: got %b expected 0", con_valid); else pass_cnt++;
    total_cnt++; if (con_data !== 8'h00) $display("FAIL reset_con_data: got %h expected 00", con_data); else pass_cnt++;
    total_cnt++; if (done !== 1'b0 || tohost !== 32'd0) $display("FAIL reset_tohost: got done=%b tohost=%h expected 0/0", done, tohost); else pass_cnt++;
    total_cnt++; if (bus.drdata !== 32'd0) $display("FAIL reset_cycle_read: got %h expected 0", bus.drdata); else pass_cnt++;
    drive(32'h8000_0008, 32'd0, 4'b0000);
    #1;
    total_cnt++; if (bus.drdata !== 32'h2) $display("FAIL reset_stat: got %h expected 00000002", bus.drdata); else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_ram();
    drive(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111); cyc();
    drive(32'h0000_0010, 32'h0000_5500, 4'b0010); cyc();
    drive(32'h0000_0010, 32'd0, 4'b0000); #1;
    total_cnt++; if (bus.drdata !== 32'hDEAD_55EF) $display("FAIL ram_bytemask: got %h expected DEAD55EF", bus.drdata); else pass_cnt++;
    drive(32'h0000_0010 + 4 * WORDS, 32'd0, 4'b0000); #1;
    total_cnt++; if (bus.drdata !== 32'hDEAD_55EF) $display("FAIL ram_wrap: got %h expected DEAD55EF", bus.drdata); else pass_cnt++;
    drive(32'h0000_0013, 32'h1111_1111, 4'b1111); #1;
    total_cnt++; if (bus.drdata !== 32'hDEAD_55EF) $display("FAIL ram_same_cycle_old: got %h expected DEAD55EF", bus.drdata); else pass_cnt++;
    cyc();
    drive(32'h0000_0010, 32'd0, 4'b0000); #1;
    total_cnt++; if (bus.drdata !== 32'h1111_1111) $display("FAIL ram_after_write: got %h expected 11111111", bus.drdata); else pass_cnt++;
  endtask

  task automatic test_cycle();
    rst = 1'b0; drive(32'h8000_0000, 32'd0, 4'b0000); cyc();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    total_cnt++; if (bus.drdata !== 32'd10) $display("FAIL cycle_count: got %0d expected 10", bus.drdata); else pass_cnt++;
    drive(32'h8000_0000, 32'h0000_1234, 4'b1111); cyc();
    drive(32'h8000_0000, 32'd0, 4'b0000); #1;
    total_cnt++; if (bus.drdata !== 32'd11) $display("FAIL cycle_write_ignored: got %h expected 0000000b", bus.drdata); else pass_cnt++;
  endtask

  task automatic test_console();
    con_ready = 1'b0;
    drive(32'h8000_0004, 32'h48, 4'b0001); cyc();
    drive(32'h8000_0004, 32'h69, 4'b0001); cyc();
    drive(32'h8000_0008, 32'd0, 4'b0000); #1;
    total_cnt++; if (bus.drdata !== 32'h20) $display("FAIL console_stat_two: got %h expected 00000020", bus.drdata); else pass_cnt++;
    total_cnt++; if (con_valid !== 1'b1 || con_data !== 8'h48) $display("FAIL console_head_h: got v=%b d=%h expected 1/48", con_valid, con_data); else pass_cnt++;
    con_ready = 1'b1; cyc();
    total_cnt++; if (con_valid !== 1'b1 || con_data !== 8'h69) $display("FAIL console_head_i: got v=%b d=%h expected 1/69", con_valid, con_data); else pass_cnt++;
    cyc();
    total_cnt++; if (con_valid !== 1'b0) $display("FAIL console_drained: got %b expected 0", con_valid); else pass_cnt++;
    total_cnt++; if (bus.drdata !== 32'h2) $display("FAIL console_stat_empty: got %h expected 00000002", bus.drdata); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_seq [8];
    exp_seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hBB};
    con_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(32'h8000_0004, 32'(8'hA0 + i), 4'b0001); cyc();
    end
    drive(32'h8000_0008, 32'd0, 4'b0000); #1;
    total_cnt++; if (bus.drdata !== 32'h85) $display("FAIL overflow_stat: got %h expected 00000085", bus.drdata); else pass_cnt++;
    con_ready = 1'b1;
    drive(32'h8000_0004, 32'hBB, 4'b0001); cyc();
    drive(32'h8000_0008, 32'd0, 4'b0000); #1;
    total_cnt++; if (bus.drdata !== 32'h85) $display("FAIL full_push_pop_stat: got %h expected 00000085", bus.drdata); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (con_valid !== 1'b1 || con_data !== exp_seq[i])
        $display("FAIL overflow_drain[%0d]: got v=%b d=%h expected 1/%h", i, con_valid, con_data, exp_seq[i]);
      else pass_cnt++;
      cyc();
    end
    total_cnt++; if (con_valid !== 1'b0 || bus.drdata !== 32'h6) $display("FAIL overflow_after_drain: got v=%b stat=%h expected 0/00000006", con_valid, bus.drdata); else pass_cnt++;
  endtask

  task automatic test_tohost();
    drive(32'h8000_000C, 32'h0000_0001, 4'b0001); cyc();
    total_cnt++; if (done !== 1'b1 || tohost !== 32'd1) $display("FAIL tohost_write: got done=%b tohost=%h expected 1/00000001", done, tohost); else pass_cnt++;
    drive(32'h8000_000C, 32'hAABB_CCDD, 4'b0100); cyc();
    total_cnt++; if (tohost !== 32'h00BB_0001) $display("FAIL tohost_bytemask: got %h expected 00BB0001", tohost); else pass_cnt++;
    con_ready = 1'b0;
    drive(32'h8000_0004, 32'h55, 4'b0001); cyc();
    rst = 1'b0;
    drive(32'h8000_000C, 32'hFFFF_FFFF, 4'b1111); cyc();
    rst = 1'b1;
    drive(32'h8000_0000, 32'd0, 4'b0000); #1;
    total_cnt++; if (done !== 1'b0 || tohost !== 32'd0) $display("FAIL reset_clears_tohost: got done=%b tohost=%h expected 0/0", done, tohost); else pass_cnt++;
    total_cnt++; if (con_valid !== 1'b0 || bus.drdata !== 32'd0) $display("FAIL reset_clears_fifo_cycle: got v=%b cycle=%h expected 0/0", con_valid, bus.drdata); else pass_cnt++;
    drive(32'h8000_0008, 32'd0, 4'b0000); #1;
    total_cnt++; if (bus.drdata !== 32'h2) $display("FAIL reset_clears_overflow: got %h expected 00000002", bus.drdata); else pass_cnt++;
  endtask

  task automatic test_alias();
    con_ready = 1'b0;
    drive(32'h8000_0014, 32'h0000_0077, 4'b0001); cyc();
    total_cnt++; if (con_valid !== 1'b1 || con_data !== 8'h77) $display("FAIL alias_push: got v=%b d=%h expected 1/77", con_valid, con_data); else pass_cnt++;
    drive(32'h8000_0004, 32'h0000_0088, 4'b1110); cyc();
    drive(32'hFFFF_FFF8, 32'd0, 4'b0000); #1;
    total_cnt++; if (bus.drdata !== 32'h10) $display("FAIL no_push_we0_clear: got %h expected 00000010", bus.drdata); else pass_cnt++;
    drive(32'h8000_0004, 32'd0, 4'b0000); #1;
    total_cnt++; if (bus.drdata !== 32'd0) $display("FAIL console_tx_reads_zero: got %h expected 0", bus.drdata); else pass_cnt++;
    con_ready = 1'b1; cyc();
  endtask

  task automatic test_random();
    logic [31:0] a;
    int op;
    drive(32'd0, 32'd0, 4'b0000);
    for (int w = 0; w < 16; w++) begin
      drive(32'(w * 4), $urandom, 4'b1111); cyc();
    end
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 2);
      con_ready = 1'($urandom_range(0, 1));
      case (op)
        0: a = 32'($urandom_range(0, 15) * 4) + ($urandom_range(0, 1) ? 32'h1000 : 32'h0) + 32'($urandom_range(0, 3));
        1: a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 255)) << 4);
        default: a = 32'h8000_0004;
      endcase
      drive(a, $urandom, 4'($urandom_range(0, 15)));
      #1;
      total_cnt++;
      if (bus.drdata !== mread(a)) $display("FAIL rand_drdata[%0d]: addr %h got %h expected %h", i, a, bus.drdata, mread(a)); else pass_cnt++;
      total_cnt++;
      if (con_valid !== (mq.size() != 0) || (mq.size() != 0 && con_data !== mq[0]))
        $display("FAIL rand_console[%0d]: got v=%b d=%h expected v=%b", i, con_valid, con_data, mq.size() != 0);
      else pass_cnt++;
      total_cnt++;
      if (done !== mdone || tohost !== mtohost) $display("FAIL rand_tohost[%0d]: got %b/%h expected %b/%h", i, done, tohost, mdone, mtohost); else pass_cnt++;
      cyc();
    end
  endtask

  initial begin
    rst = 1'b0;
    con_ready = 1'b0;
    drive(32'd0, 32'd0, 4'b0000);
    mcyc = 32'd0; movf = 1'b0; mdone = 1'b0; mtohost = 32'd0;
    test_reset();
    test_ram();
    test_cycle();
    test_console();
    test_overflow();
    test_tohost();
    test_alias();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
